// File: rtl/sobel_window_gen.sv
// ---------------------------------------------------------------------------
// sobel_window_gen
//
// Streaming front end for the Sobel datapath. Takes a raster-order pixel
// stream (one pixel per s_valid/s_ready handshake), keeps two line buffers
// plus a small column shift window, and emits one zero-padded 3x3
// neighbourhood per image pixel in raster order of its centre.
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - synchronous, active-high reset
//   s_valid    - input pixel valid
//   s_ready    - block can accept a pixel this cycle
//   s_data     - input pixel (BYTE_SIZE bits, unsigned)
//   m_valid    - output window valid
//   m_ready    - downstream accepts the window
//   m_win      - 3x3 window, element k=3*r+c (top-left first) at
//                bits [k*BYTE_SIZE +: BYTE_SIZE]
//   m_row      - centre row of m_win
//   m_col      - centre column of m_win
//   m_last     - m_win is centred on the last pixel of the frame
//   frame_done - one-cycle pulse after the last window handshake
// ---------------------------------------------------------------------------
module sobel_window_gen #(
  parameter int IMAGE_WIDTH_E = 9,
  parameter int IMAGE_HIGHT_E = 9,
  parameter int IMAGE_WIDTH   = 2**IMAGE_WIDTH_E,
  parameter int IMAGE_HIGHT   = 2**IMAGE_HIGHT_E,
  parameter int BYTE_SIZE     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [BYTE_SIZE-1:0]     s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [9*BYTE_SIZE-1:0]   m_win,
  output logic [IMAGE_HIGHT_E-1:0] m_row,
  output logic [IMAGE_WIDTH_E-1:0] m_col,
  output logic                     m_last,
  output logic                     frame_done
);

  typedef enum logic [1:0] {RUN, EDGE, FLUSH, DONE} state_t;

  // One column of the window: index 0 = top row, 2 = bottom row
  typedef logic [2:0][BYTE_SIZE-1:0] col_t;

  localparam logic [IMAGE_WIDTH_E-1:0] LAST_COL  = (IMAGE_WIDTH_E)'(IMAGE_WIDTH - 1);
  localparam logic [IMAGE_HIGHT_E-1:0] LAST_ROW  = (IMAGE_HIGHT_E)'(IMAGE_HIGHT - 1);
  localparam logic [IMAGE_WIDTH_E:0]   FLUSH_END = (IMAGE_WIDTH_E+1)'(IMAGE_WIDTH);

  state_t                   state;
  logic [IMAGE_HIGHT_E-1:0] ri;
  logic [IMAGE_WIDTH_E-1:0] ci;
  logic [IMAGE_WIDTH_E:0]   fc;

  // lb0 holds row ri-2, lb1 holds row ri-1, both indexed by column
  logic [BYTE_SIZE-1:0] lb0 [IMAGE_WIDTH];
  logic [BYTE_SIZE-1:0] lb1 [IMAGE_WIDTH];

  // Only the two most recent columns are kept; the third (newest) column is
  // the incoming colvec, so the output register holds the post-shift window.
  col_t mid_col;
  col_t right_col;

  logic                     adv;
  logic                     accept;
  logic                     step;
  logic                     col_clear;
  logic                     emit;
  logic                     emit_last;
  logic [IMAGE_HIGHT_E-1:0] emit_row;
  logic [IMAGE_WIDTH_E-1:0] emit_col;
  logic [IMAGE_WIDTH_E-1:0] flush_idx;
  logic                     row_ge1;
  logic                     row_ge2;
  col_t                     colvec;
  logic [9*BYTE_SIZE-1:0]   window;

  assign adv     = !m_valid || m_ready;
  assign s_ready = (state == RUN) && adv;
  assign accept  = s_valid && s_ready;

  assign row_ge1   = (ri != '0);
  assign row_ge2   = row_ge1 && (ri != (IMAGE_HIGHT_E)'(1));
  assign flush_idx = fc[IMAGE_WIDTH_E-1:0];

  // Per-state datapath control: which column enters the shift window, whether
  // the window shifts this cycle, and which centre (if any) is emitted.
  always_comb begin
    step      = 1'b0;
    col_clear = 1'b0;
    emit      = 1'b0;
    emit_last = 1'b0;
    emit_row  = '0;
    emit_col  = '0;
    colvec    = '0;
    case (state)
      RUN: begin
        colvec[0] = row_ge2 ? lb0[ci] : '0;
        colvec[1] = row_ge1 ? lb1[ci] : '0;
        colvec[2] = s_data;
        step      = accept;
        col_clear = (ci == '0);
        emit      = accept && row_ge1 && (ci != '0);
        emit_row  = ri - (IMAGE_HIGHT_E)'(1);
        emit_col  = ci - (IMAGE_WIDTH_E)'(1);
      end
      EDGE: begin
        step     = adv;
        emit     = adv;
        emit_row = ri - (IMAGE_HIGHT_E)'(1);
        emit_col = LAST_COL;
      end
      FLUSH: begin
        // Below the last row is padding, so the bottom element stays zero;
        // one step past the last column shifts in the all-zero right border.
        if (fc != FLUSH_END) begin
          colvec[0] = lb0[flush_idx];
          colvec[1] = lb1[flush_idx];
        end
        step      = adv;
        col_clear = (fc == '0);
        emit      = adv && (fc != '0);
        emit_row  = LAST_ROW;
        emit_col  = flush_idx - (IMAGE_WIDTH_E)'(1);
        emit_last = (fc == FLUSH_END);
      end
      default: ;
    endcase
  end

  // Assemble the 3x3 window from the two held columns and the incoming one
  always_comb begin
    window = '0;
    for (int r = 0; r < 3; r++) begin
      window[(3*r)*BYTE_SIZE +: BYTE_SIZE]   = mid_col[r];
      window[(3*r+1)*BYTE_SIZE +: BYTE_SIZE] = right_col[r];
      window[(3*r+2)*BYTE_SIZE +: BYTE_SIZE] = colvec[r];
    end
  end

  // Line buffers are plain storage; they are never read before being written
  // in the current frame because the row>=1 / row>=2 gates mask them.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0[ci] <= lb1[ci];
      lb1[ci] <= s_data;
    end
  end

  // Control FSM, shift window and registered output stage
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      ri         <= '0;
      ci         <= '0;
      fc         <= '0;
      mid_col    <= '0;
      right_col  <= '0;
      m_valid    <= 1'b0;
      m_win      <= '0;
      m_row      <= '0;
      m_col      <= '0;
      m_last     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (step) begin
        if (col_clear) begin
          mid_col   <= '0;
          right_col <= colvec;
        end else begin
          mid_col   <= right_col;
          right_col <= colvec;
        end
      end

      if (adv) begin
        m_valid <= emit;
        if (emit) begin
          m_win  <= window;
          m_row  <= emit_row;
          m_col  <= emit_col;
          m_last <= emit_last;
        end
      end

      case (state)
        RUN: begin
          if (accept) begin
            if (ci == LAST_COL) begin
              ci <= '0;
              // Row 0 has nothing to close off; later rows still owe the
              // right-edge window of the row above.
              if (!row_ge1) begin
                ri <= (IMAGE_HIGHT_E)'(1);
              end else begin
                state <= EDGE;
              end
            end else begin
              ci <= ci + (IMAGE_WIDTH_E)'(1);
            end
          end
        end
        EDGE: begin
          if (adv) begin
            if (ri == LAST_ROW) begin
              fc    <= '0;
              state <= FLUSH;
            end else begin
              ri    <= ri + (IMAGE_HIGHT_E)'(1);
              state <= RUN;
            end
          end
        end
        FLUSH: begin
          if (adv) begin
            if (fc == FLUSH_END) begin
              state <= DONE;
            end else begin
              fc <= fc + (IMAGE_WIDTH_E+1)'(1);
            end
          end
        end
        DONE: begin
          // The only window still in flight here is the m_last one
          if (m_valid && m_ready) begin
            frame_done <= 1'b1;
            ri         <= '0;
            ci         <= '0;
            fc         <= '0;
            state      <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_window_gen.sv
// ---------------------------------------------------------------------------
// tb_sobel_window_gen
//
// Self-checking bench for sobel_window_gen on a 4x4 image. Stimulus tasks
// push every expected window of a frame into a scoreboard queue; an
// independent monitor pops and compares on every output handshake.
// ---------------------------------------------------------------------------
module tb_sobel_window_gen;

  localparam int WE = 2;
  localparam int HE = 2;
  localparam int W  = 1 << WE;
  localparam int H  = 1 << HE;
  localparam int B  = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            s_valid;
  logic            s_ready;
  logic [B-1:0]    s_data;
  logic            m_valid;
  logic            m_ready;
  logic [9*B-1:0]  m_win;
  logic [HE-1:0]   m_row;
  logic [WE-1:0]   m_col;
  logic            m_last;
  logic            frame_done;

  typedef struct packed {
    logic [9*B-1:0] win;
    logic [HE-1:0]  row;
    logic [WE-1:0]  col;
    logic           last;
  } exp_t;

  exp_t           sbQueue[$];
  int             checks    = 0;
  int             errors    = 0;
  int             doneCount = 0;
  int             img[H][W];
  logic [9*B-1:0] got[H][W];
  bit             bpMode = 1'b0;
  bit             latPend = 1'b0;
  int             latRow;
  int             latCol;

  sobel_window_gen #(
    .IMAGE_WIDTH_E(WE),
    .IMAGE_HIGHT_E(HE),
    .BYTE_SIZE(B)
  ) dut (
    .clk(clk),
    .reset(reset),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_win(m_win),
    .m_row(m_row),
    .m_col(m_col),
    .m_last(m_last),
    .frame_done(frame_done)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Zero-padded 3x3 neighbourhood of the current image, straight from the
  // definition: any coordinate outside the image reads as zero.
  function automatic logic [9*B-1:0] modelWindow(input int r, input int c);
    logic [9*B-1:0] w;
    int rr;
    int cc;
    w = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        rr = r + dr;
        cc = c + dc;
        if (rr >= 0 && rr < H && cc >= 0 && cc < W)
          w[(3*(dr+1)+(dc+1))*B +: B] = B'(img[rr][cc]);
      end
    end
    return w;
  endfunction

  function automatic logic [9*B-1:0] pack9(input int e0, input int e1, input int e2,
                                           input int e3, input int e4, input int e5,
                                           input int e6, input int e7, input int e8);
    return {B'(e8), B'(e7), B'(e6), B'(e5), B'(e4), B'(e3), B'(e2), B'(e1), B'(e0)};
  endfunction

  task automatic checkVal(input string name, input logic [9*B-1:0] act,
                          input logic [9*B-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pops the next expected window and compares it with the DUT output
  task automatic checkOutput();
    exp_t e;
    checks++;
    if (sbQueue.size() == 0) begin
      errors++;
      $display("[TB] FAIL window: unexpected output row %0d col %0d win %h",
               m_row, m_col, m_win);
    end else begin
      e = sbQueue.pop_front();
      if (m_win !== e.win || m_row !== e.row || m_col !== e.col || m_last !== e.last) begin
        errors++;
        $display("[TB] FAIL window: got (%0d,%0d) last %0b %h expected (%0d,%0d) last %0b %h",
                 m_row, m_col, m_last, m_win, e.row, e.col, e.last, e.win);
      end
      got[m_row][m_col] = m_win;
    end
  endtask

  // Window for pixel (r,c) must appear the cycle after pixel (r+1,c+1)
  task automatic checkLatency();
    if (latPend) begin
      checks++;
      if (!(m_valid === 1'b1 && int'(m_row) == latRow && int'(m_col) == latCol)) begin
        errors++;
        $display("[TB] FAIL latency: got valid %0b (%0d,%0d) expected valid 1 (%0d,%0d)",
                 m_valid, m_row, m_col, latRow, latCol);
      end
      latPend = 1'b0;
    end
  endtask

  task automatic checkResetState(input string tag);
    checkVal({tag, " m_valid"}, 72'(m_valid), 72'(0));
    checkVal({tag, " m_win"}, m_win, 72'(0));
    checkVal({tag, " m_row"}, 72'(m_row), 72'(0));
    checkVal({tag, " m_col"}, 72'(m_col), 72'(0));
    checkVal({tag, " m_last"}, 72'(m_last), 72'(0));
    checkVal({tag, " frame_done"}, 72'(frame_done), 72'(0));
    checkVal({tag, " s_ready"}, 72'(s_ready), 72'(1));
  endtask

  // Monitor: compares every handshaked window and checks that a stalled
  // output holds steady until it is taken.
  logic [9*B-1:0] heldWin;
  logic [HE-1:0]  heldRow;
  logic [WE-1:0]  heldCol;
  bit             held = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      held = 1'b0;
    end else begin
      if (held) begin
        checks++;
        if (m_valid !== 1'b1 || m_win !== heldWin || m_row !== heldRow || m_col !== heldCol) begin
          errors++;
          $display("[TB] FAIL hold: got valid %0b (%0d,%0d) %h expected valid 1 (%0d,%0d) %h",
                   m_valid, m_row, m_col, m_win, heldRow, heldCol, heldWin);
        end
      end
      if (frame_done === 1'b1) doneCount++;
      if (m_valid === 1'b1 && m_ready === 1'b1) checkOutput();
      held    = (m_valid === 1'b1) && (m_ready === 1'b0);
      heldWin = m_win;
      heldRow = m_row;
      heldCol = m_col;
    end
  end

  // Downstream ready: always 1, or the 1,0,0,1 pattern under backpressure
  initial begin
    int phase;
    phase   = 0;
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bpMode) begin
        m_ready = (phase == 0 || phase == 3);
        phase   = (phase + 1) % 4;
      end else begin
        m_ready = 1'b1;
      end
    end
  end

  // Builds one frame, queues all of its expected windows, then streams its
  // pixels (optionally gapped). stopAfter < 0 sends the whole frame.
  task automatic applyStimulus(input int base, input bit randImg, input bit gaps,
                               input bit timing, input int stopAfter);
    int idx;
    int budget;
    int stalls;
    int limit;
    exp_t e;
    idx    = 0;
    budget = 0;
    stalls = 0;
    limit  = (stopAfter < 0) ? W*H : stopAfter;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = randImg ? int'($urandom_range(0, 255)) : (W*r + c + 1 + base);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        e.win  = modelWindow(r, c);
        e.row  = HE'(r);
        e.col  = WE'(c);
        e.last = (r == H-1 && c == W-1);
        sbQueue.push_back(e);
      end
    end
    while (idx < limit && budget < 4000) begin
      @(posedge clk);
      #1;
      s_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_data  = B'(img[idx / W][idx % W]);
      @(negedge clk);
      checkLatency();
      if (s_valid && !s_ready) stalls++;
      if (s_valid && s_ready) begin
        if (timing && (idx / W) >= 1 && (idx % W) >= 1) begin
          latPend = 1'b1;
          latRow  = idx / W - 1;
          latCol  = idx % W - 1;
        end
        idx++;
      end
      budget++;
    end
    if (idx < limit) begin
      checks++;
      errors++;
      $display("[TB] FAIL input timeout: got %0d pixels accepted expected %0d", idx, limit);
    end
    if (timing && stopAfter < 0) begin
      // Only the right-edge cycles of rows 1..H-2 fall between pixels
      checkVal("in-frame stalls", 72'(stalls), 72'(H - 2));
    end
  endtask

  // Waits for frame_done to bring the pulse count up to target
  task automatic drainFrame(input int target, input bit timing);
    int budget;
    int stalls;
    budget = 0;
    stalls = 0;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    while (doneCount < target && budget < 1000) begin
      @(negedge clk);
      checkLatency();
      if (frame_done !== 1'b1 && s_ready !== 1'b1) stalls++;
      budget++;
    end
    checkVal("frame_done count", 72'(doneCount), 72'(target));
    checkVal("scoreboard empty", 72'(sbQueue.size()), 72'(0));
    if (timing) begin
      // One EDGE cycle, W+1 flush cycles, one DONE cycle
      checkVal("tail stalls", 72'(stalls), 72'(W + 3));
    end
  endtask

  // Main sequence
  initial begin
    reset   = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkResetState("reset");

    $display("[TB] basic frame");
    applyStimulus(0, 1'b0, 1'b0, 1'b1, -1);
    drainFrame(1, 1'b1);
    checkVal("win(0,0)", got[0][0], pack9(0,0,0, 0,1,2, 0,5,6));
    checkVal("win(1,1)", got[1][1], pack9(1,2,3, 5,6,7, 9,10,11));
    checkVal("win(3,3)", got[3][3], pack9(11,12,0, 15,16,0, 0,0,0));
    checkVal("win(0,3)", got[0][3], pack9(0,0,0, 3,4,0, 7,8,0));
    checkVal("win(2,0)", got[2][0], pack9(0,5,6, 0,9,10, 0,13,14));

    $display("[TB] backpressure");
    bpMode = 1'b1;
    applyStimulus(0, 1'b0, 1'b1, 1'b0, -1);
    drainFrame(2, 1'b0);
    bpMode = 1'b0;

    $display("[TB] back-to-back frames");
    applyStimulus(0, 1'b0, 1'b0, 1'b0, -1);
    applyStimulus(100, 1'b0, 1'b0, 1'b0, -1);
    drainFrame(4, 1'b0);
    checkVal("frame B win(0,0)", got[0][0], pack9(0,0,0, 0,101,102, 0,105,106));

    $display("[TB] reset mid-frame");
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 9);
    @(posedge clk);
    #1;
    reset   = 1'b1;
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sbQueue.delete();
    latPend = 1'b0;
    @(negedge clk);
    checkResetState("mid-frame reset");
    applyStimulus(0, 1'b0, 1'b0, 1'b1, -1);
    drainFrame(5, 1'b1);

    $display("[TB] random frames");
    for (int f = 0; f < 3; f++) begin
      bpMode = f[0];
      applyStimulus(0, 1'b1, 1'b1, 1'b0, -1);
      drainFrame(6 + f, 1'b0);
    end
    bpMode = 1'b0;
    applyStimulus(0, 1'b1, 1'b0, 1'b0, -1);
    applyStimulus(0, 1'b1, 1'b0, 1'b0, -1);
    drainFrame(10, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
